// File: rtl/int_entry.sv
// 6502 interrupt / BRK entry sequencer: pushes PCH, PCL and P, fetches the
// vector, then strobes the new PC. Owns NMI edge detection and NMI hijack.
module int_entry #(
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        rst_req,
  input  logic        nmi_req,
  input  logic        irq_req,
  input  logic        brk,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  data_in,
  output logic        busy,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        rw,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_out,
  output logic        set_i
);

  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI} state_t;
  typedef enum logic [2:0] {K_NONE, K_RST, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        nmi_prev_q, nmi_prev_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic [15:0] pc_save_q, pc_save_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [15:0] vec_q, vec_d;
  logic        vec_nmi_q, vec_nmi_d;
  logic        nmi_set, nmi_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      kind_q        <= K_NONE;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
      pc_save_q     <= 16'h0;
      vec_lo_q      <= 8'h0;
      vec_q         <= 16'h0;
      vec_nmi_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
      pc_save_q     <= pc_save_d;
      vec_lo_q      <= vec_lo_d;
      vec_q         <= vec_d;
      vec_nmi_q     <= vec_nmi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    pc_save_d  = pc_save_q;
    vec_lo_d   = vec_lo_q;
    vec_d      = vec_q;
    vec_nmi_d  = vec_nmi_q;
    nmi_prev_d = nmi_req;
    nmi_set    = nmi_req & ~nmi_prev_q;
    nmi_clr    = 1'b0;
    busy       = 1'b0;
    addr       = 16'h0;
    data_out   = 8'h0;
    rw         = 1'b1;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    pc_out     = 16'h0;
    set_i      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sync && rst_req) begin
          kind_d = K_RST; vec_d = RST_VEC; vec_nmi_d = 1'b0; state_d = PUSH_PCH;
        end else if (sync && nmi_pending_q) begin
          kind_d = K_NMI; vec_d = NMI_VEC; vec_nmi_d = 1'b1; state_d = PUSH_PCH;
        end else if (sync && irq_req && !i_flag) begin
          kind_d = K_IRQ; vec_d = IRQ_VEC; vec_nmi_d = 1'b0; state_d = PUSH_PCH;
        end else if (brk) begin
          kind_d = K_BRK; vec_d = IRQ_VEC; vec_nmi_d = 1'b0; state_d = PUSH_PCH;
        end
        if (state_d == PUSH_PCH) pc_save_d = pc_in;
      end
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        busy   = 1'b1;
        addr   = {8'h01, sp_in};
        rw     = (kind_q == K_RST);   // reset walks the stack with dummy reads
        sp_dec = 1'b1;
        case (state_q)
          PUSH_PCH: begin data_out = pc_save_q[15:8]; state_d = PUSH_PCL; end
          PUSH_PCL: begin data_out = pc_save_q[7:0];  state_d = PUSH_P;   end
          default: begin
            data_out = {p_in[7:6], 1'b1, kind_q == K_BRK, p_in[3:0]};
            state_d  = VEC_LO;
            // A late NMI steals the vector; the pushed B bit stays as is.
            if ((kind_q == K_IRQ || kind_q == K_BRK) && nmi_pending_q) begin
              vec_d     = NMI_VEC;
              vec_nmi_d = 1'b1;
            end
          end
        endcase
      end
      VEC_LO: begin
        busy     = 1'b1;
        addr     = vec_q;
        vec_lo_d = data_in;
        state_d  = VEC_HI;
      end
      VEC_HI: begin
        busy    = 1'b1;
        addr    = vec_q + 16'd1;
        pc_out  = {data_in, vec_lo_q};
        pc_load = 1'b1;
        set_i   = 1'b1;
        nmi_clr = vec_nmi_q;
        kind_d  = K_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    nmi_pending_d = nmi_set | (nmi_pending_q & ~nmi_clr);
  end

endmodule

// File: doc/int_entry.md
Name: int_entry

Overview:
Consumes the prioritised rst/nmi/irq request lines from the interrupt sequencer and runs the 6502 interrupt/BRK entry sequence. The sequence is: push PCH, push PCL, push P, fetch the vector low byte, fetch the vector high byte, then load the new PC. The block owns NMI edge detection, IRQ masking by the I flag and NMI hijack of IRQ/BRK. While busy it drives the CPU bus in place of the normal execution path.

Parameters:
RST_VEC, 16'hFFFC, reset vector address (low byte; high byte at +1)
NMI_VEC, 16'hFFFA, NMI vector address
IRQ_VEC, 16'hFFFE, IRQ/BRK vector address

Ports:
clk  input  1  CPU clock; all state updates on rising edge
rst  input  1  asynchronous, active-high block reset
sync  input  1  high during the opcode-fetch cycle (instruction boundary)
rst_req  input  1  reset request from interrupt sequencer (level)
nmi_req  input  1  NMI request from interrupt sequencer (level; edge detected here)
irq_req  input  1  IRQ request from interrupt sequencer (level)
brk  input  1  one-cycle pulse from decoder: BRK opcode fetched
i_flag  input  1  current P.I
pc_in  input  16  PC to be pushed (sampled on entry)
p_in  input  8  current P register
sp_in  input  8  current stack pointer (register file applies sp_dec at clock edge)
data_in  input  8  read data bus
busy  output  1  sequence in progress; core must not drive the bus
addr  output  16  bus address while busy
data_out  output  8  write data while busy
rw  output  1  1=read, 0=write
sp_dec  output  1  decrement SP at end of this cycle
pc_load  output  1  one-cycle strobe: load pc_out into PC
pc_out  output  16  new PC (vector contents)
set_i  output  1  one-cycle strobe: set P.I (coincident with pc_load)

Behaviour:
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI. Registered state; outputs decode from state plus latched registers.
- Reset (async): state=IDLE, nmi_pending=0, nmi_prev=1, kind=none, pc_save=0, vec_lo=0. Outputs while in IDLE: busy=0, rw=1, addr=0, data_out=0, sp_dec=0, pc_load=0, set_i=0, pc_out=0.
- NMI edge: nmi_prev<=nmi_req each cycle. nmi_pending set when nmi_req & ~nmi_prev. Cleared on the VEC_HI cycle when the NMI vector is used. If set and clear coincide, set wins.
- Start (IDLE only) is evaluated in this priority order:
  - sync & rst_req -> kind=RST
  - sync & nmi_pending -> kind=NMI
  - sync & irq_req & ~i_flag -> kind=IRQ
  - brk -> kind=BRK
  - On start: pc_save<=pc_in; next state=PUSH_PCH.
- Requests arriving while busy are not started. rst_req/irq_req are re-evaluated at the next sync after return to IDLE. nmi_pending remains latched.
- PUSH_PCH: addr={8'h01,sp_in}, data_out=pc_save[15:8], sp_dec=1. rw=0, except rw=1 for kind RST (reset does dummy reads but still decrements SP).
- PUSH_PCL: same as PUSH_PCH with pc_save[7:0].
- PUSH_P: same as PUSH_PCH with data_out = p_in with bit5=1 and bit4=(kind==BRK).
- Hijack: at the end of PUSH_P, if kind is IRQ or BRK and nmi_pending=1, the vector becomes NMI_VEC. B in the pushed P is unchanged.
- VEC_LO: rw=1, addr=vector; vec_lo<=data_in.
- VEC_HI: rw=1, addr=vector+1; pc_out={data_in,vec_lo}; pc_load=1; set_i=1. Next state=IDLE.
- Latency: start cycle +5 busy cycles. pc_load is asserted in the 5th busy cycle.
- Async rst mid-sequence aborts immediately to IDLE with no pc_load. A pending NMI is lost.
- busy=1 in every non-IDLE state.

Test Plan:
- IRQ entry: i_flag=0, irq_req=1, sync=1, pc_in=16'h1234, sp_in=8'hFD stepping, p_in=8'h00, mem[FFFE]=8'h00, mem[FFFF]=8'h80 -> writes 0x01FD=12, 0x01FC=34, 0x01FB=20. Then reads FFFE, FFFF; pc_out=16'h8000 with pc_load and set_i high for 1 cycle. busy is high 5 cycles.
- Masked IRQ: i_flag=1, irq_req=1 over 10 syncs -> busy stays 0, no bus activity.
- NMI edge: nmi_req rises and stays high across 3 syncs, vector 16'hC000 -> exactly one sequence, addr FFFA/FFFB, pc_out=C000. No second entry until nmi_req falls and rises again.
- Reset: rst_req=1 at sync, sp_in=00 -> three cycles with rw=1 at 0x0100, 0x01FF, 0x01FE, sp_dec each cycle. Then fetches FFFC/FFFD.
- BRK with hijack: brk pulse, p_in=8'h01; nmi_req rises during PUSH_PCL -> pushed P=8'h31; vector FFFA/FFFB; nmi_pending clear afterwards.
- Async rst asserted during VEC_LO -> busy=0 in the same cycle, no pc_load. After release and a sync, no start occurs unless a new request is present.
